// File: rtl/float_div_iter.sv
// float_div_iter: iterative IEEE-754 single divider, radix-2 restoring, fixed latency start/done handshake
module float_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int ITERS = MAN_W + 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [EXP_W+MAN_W:0]   OUT_FDIV,
  output logic [3:0]             EXC,
  output logic                   Flag_FDIV
);
  localparam int W = EXP_W + MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(ITERS + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  typedef enum logic [1:0] {IDLE, PREP, ITER, RND} state_t;
  state_t state;
  logic [W-1:0] a_q, b_q;
  logic [MAN_W+1:0] r;
  logic [MAN_W:0] mb;
  logic [EW-1:0] e;
  logic [ITERS-1:0] q;
  logic [CW-1:0] cnt;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0] ma0, mb0, rem, mant;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn, invalid, special, dz, ge, up, carry, ovf, unf;
  logic [W-1:0] inf_v, zero_v, qnan, res;
  logic [EW-1:0] e_r;
  logic [3:0] exc;
  assign ea = a_q[W-2:MAN_W];
  assign eb = b_q[W-2:MAN_W];
  assign ma0 = {1'b1, a_q[MAN_W-1:0]};
  assign mb0 = {1'b1, b_q[MAN_W-1:0]};
  // subnormals are flushed: any zero exponent is treated as a signed zero
  assign a_zero = ea == '0;
  assign b_zero = eb == '0;
  assign a_inf = ea == EMAX && a_q[MAN_W-1:0] == '0;
  assign b_inf = eb == EMAX && b_q[MAN_W-1:0] == '0;
  assign a_nan = ea == EMAX && a_q[MAN_W-1:0] != '0;
  assign b_nan = eb == EMAX && b_q[MAN_W-1:0] != '0;
  assign sgn = a_q[W-1] ^ b_q[W-1];
  assign invalid = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
  assign special = invalid | a_inf | a_zero | b_zero | b_inf;
  assign dz = ~invalid & ~a_inf & b_zero;
  assign inf_v = {sgn, EMAX, {MAN_W{1'b0}}};
  assign zero_v = {sgn, {(W-1){1'b0}}};
  assign qnan = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  // the partial remainder is always below 2*mb, so the subtraction fits in MAN_W+1 bits
  assign ge = r >= {1'b0, mb};
  assign rem = ge ? r[MAN_W:0] - mb : r[MAN_W:0];
  assign up = q[1] & (q[0] | (|r) | q[2]);
  assign {carry, mant} = {1'b0, q[ITERS-1:2]} + (MAN_W+2)'(up);
  assign e_r = e + EW'(carry);
  assign ovf = ~e_r[EW-1] & (e_r >= {2'b00, EMAX});
  assign unf = e_r[EW-1] | (e_r == '0);
  assign res = special ? (invalid ? qnan : (a_inf | b_zero) ? inf_v : zero_v)
             : ovf ? inf_v : unf ? zero_v
             : {sgn, e_r[EXP_W-1:0], carry ? mant[MAN_W:1] : mant[MAN_W-1:0]};
  assign exc = special ? {invalid, dz, 2'b00} : {2'b00, ovf, unf};
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      OUT_FDIV <= '0;
      EXC <= '0;
      Flag_FDIV <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (EN) begin
          a_q <= A;
          b_q <= B;
          BUSY <= 1'b1;
          state <= PREP;
        end
        PREP: begin
          r <= ma0 < mb0 ? {ma0, 1'b0} : {1'b0, ma0};
          mb <= mb0;
          e <= {2'b00, ea} - {2'b00, eb} + BIAS - EW'(ma0 < mb0);
          cnt <= '0;
          state <= ITER;
        end
        ITER: begin
          r <= {rem, 1'b0};
          q <= {q[ITERS-2:0], ge};
          cnt <= cnt + 1'b1;
          state <= cnt == CW'(ITERS - 1) ? RND : ITER;
        end
        default: begin
          OUT_FDIV <= res;
          EXC <= exc;
          Flag_FDIV <= |exc;
          DONE <= 1'b1;
          BUSY <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_float_div_iter.sv
// tb_float_div_iter: directed and random checks of float_div_iter against an integer-division reference
module tb_float_div_iter;
  logic CLK = 0, RST = 1, EN = 0;
  logic [31:0] A = 0, B = 0;
  logic BUSY, DONE, Flag_FDIV;
  logic [31:0] OUT_FDIV;
  logic [3:0] EXC;
  int tests = 0, fails = 0;
  float_div_iter dut (.CLK(CLK), .RST(RST), .EN(EN), .A(A), .B(B), .BUSY(BUSY), .DONE(DONE),
                      .OUT_FDIV(OUT_FDIV), .EXC(EXC), .Flag_FDIV(Flag_FDIV));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] x);
    int ea = int'(a[30:23]);
    int eb = int'(b[30:23]);
    logic s = a[31] ^ b[31];
    bit az = ea == 0, bz = eb == 0;
    bit ai = ea == 255 && a[22:0] == 0, bi = eb == 255 && b[22:0] == 0;
    bit an = ea == 255 && a[22:0] != 0, bn = eb == 255 && b[22:0] != 0;
    longint unsigned ma = 64'(a[22:0]) | (64'd1 << 23);
    longint unsigned mb = 64'(b[22:0]) | (64'd1 << 23);
    longint unsigned qt, rm, mant, rest, half;
    int k, e;
    x = 4'b0000;
    if (an || bn || (az && bz) || (ai && bi)) begin r = 32'h7FC00000; x = 4'b1000; end
    else if (ai) r = {s, 8'hFF, 23'h0};
    else if (bz) begin r = {s, 8'hFF, 23'h0}; x = 4'b0100; end
    else if (az || bi) r = {s, 31'h0};
    else begin
      qt = (ma << 40) / mb;
      rm = (ma << 40) % mb;
      e = ea - eb + 127;
      k = 17;
      if (ma < mb) begin k = 16; e--; end
      mant = qt >> k;
      rest = qt & ((64'd1 << k) - 1);
      half = 64'd1 << (k - 1);
      if (rest > half || (rest == half && (rm != 0 || mant[0]))) mant++;
      if (mant == (64'd1 << 24)) begin mant >>= 1; e++; end
      if (e >= 255) begin r = {s, 8'hFF, 23'h0}; x = 4'b0010; end
      else if (e <= 0) begin r = {s, 31'h0}; x = 4'b0001; end
      else r = {s, 8'(e), 23'(mant)};
    end
  endfunction
  function automatic logic [31:0] gen();
    int k = $urandom_range(0, 9);
    logic s = 1'($urandom);
    logic [22:0] f = 23'($urandom);
    logic [7:0] e = 8'($urandom_range(1, 254));
    if (k == 0) return {s, 31'h0};
    if (k == 1) return {s, 8'hFF, 23'h0};
    if (k == 2) return {s, 8'hFF, f | 23'h1};
    if (k == 3) return {s, 8'h00, f | 23'h1};
    return {s, e, f};
  endfunction
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                    input logic [3:0] ex, input string tag);
    int n = 0;
    A = a; B = b; EN = 1;
    do begin
      tick();
      n++;
      if (n == 1) begin
        EN = 0; A = $urandom; B = $urandom;
        check({tag, ":busy"}, BUSY, 1);
      end
    end while (!DONE && n < 40);
    check({tag, ":lat"}, n, 29);
    check({tag, ":out"}, OUT_FDIV, er);
    check({tag, ":exc"}, EXC, ex);
    check({tag, ":flag"}, Flag_FDIV, |ex);
    tick();
    check({tag, ":pulse"}, {BUSY, DONE}, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    logic [31:0] a, b, r1, r2;
    logic [3:0] x1, x2;
    int n, d1, d2, extra;
    repeat (3) tick();
    check("reset", {BUSY, DONE, Flag_FDIV, EXC, OUT_FDIV}, 0);
    RST = 0;
    op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, "6/2");
    op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, "1/3");
    op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, "1/0");
    op(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, "-1/0");
    op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, "0/0");
    op(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, "ovf");
    op(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, "unf");
    A = 32'h40C00000; B = 32'h40000000; EN = 1; n = 0;
    do begin
      tick();
      n++;
      if (n == 1) EN = 0;
      if (n == 4) begin EN = 1; A = 32'h3F800000; B = 32'h40400000; end
      if (n == 5) EN = 0;
    end while (!DONE && n < 40);
    check("ign:lat", n, 29);
    check("ign:out", OUT_FDIV, 32'h40400000);
    extra = 0;
    repeat (40) begin tick(); if (DONE) extra++; end
    check("ign:single", extra, 0);
    A = 32'h3F800000; B = 32'h40400000; EN = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) EN = 0;
      if (i == 9) RST = 1;
    end
    RST = 0;
    check("rst:outs", {BUSY, DONE, Flag_FDIV, EXC, OUT_FDIV}, 0);
    extra = 0;
    repeat (40) begin tick(); if (DONE) extra++; end
    check("rst:nodone", extra, 0);
    op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, "rst:6/2");
    a = {1'b0, 8'd140, 23'($urandom)}; b = {1'b1, 8'd120, 23'($urandom)};
    model(a, b, r1, x1);
    A = a; B = b; EN = 1;
    a = {1'b1, 8'd100, 23'($urandom)}; b = {1'b0, 8'd90, 23'($urandom)};
    model(a, b, r2, x2);
    d1 = 0; d2 = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 1) begin A = a; B = b; end
      if (i == 30) EN = 0;
      if (DONE && d1 == 0) begin
        d1 = i;
        check("b2b:out1", {EXC, OUT_FDIV}, {x1, r1});
      end else if (DONE && d2 == 0) begin
        d2 = i;
        check("b2b:out2", {EXC, OUT_FDIV}, {x2, r2});
      end
    end
    check("b2b:lat1", d1, 29);
    check("b2b:lat2", d2, 58);
    repeat (150) begin
      a = gen(); b = gen();
      model(a, b, r1, x1);
      op(a, b, r1, x1, "rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
